// File: rtl/ps2_lane_pkg.sv
// Shared scan-code constants, decoder states and the lane event record.
package ps2_lane_pkg;

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;

    typedef enum logic [1:0] {
        IDLE,
        BRK,
        EXT,
        EXT_BRK
    } decState_t;

    typedef struct packed {
        logic [1:0] lane;
        logic       press;
    } laneEvent_t;

endpackage

// File: rtl/key_event_fifo.sv
// First-word fall-through event FIFO; written data is visible at the head one cycle later.
// A push on a full FIFO is accepted only if a pop happens in the same cycle; otherwise it is ignored.
module key_event_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wrEn,
    input  logic [WIDTH-1:0] wrData,
    input  logic             rdEn,
    output logic [WIDTH-1:0] rdData,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtr;
    logic [AW-1:0]    rdPtr;
    logic [AW:0]      count;
    logic             doPush;
    logic             doPop;

    assign empty  = (count == '0);
    assign full   = (count == (AW+1)'(DEPTH));
    assign doPop  = rdEn && !empty;
    // When full, the slot being popped this cycle is the one the push overwrites.
    assign doPush = wrEn && (!full || doPop);
    assign rdData = empty ? '0 : mem[rdPtr];

    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr] <= wrData;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (doPop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            count <= count + {{AW{1'b0}}, doPush} - {{AW{1'b0}}, doPop};
        end
    end

endmodule

// File: rtl/ps2_lane_decoder.sv
// PS/2 scan bytes to per-lane press/release events; event visible one cycle after the byte strobe.
// Consumer stalls with ev_ready low; events arriving on a full queue are dropped and flag overflow.
module ps2_lane_decoder
    import ps2_lane_pkg::*;
#(
    parameter logic [7:0] LANE0_CODE     = 8'h23,
    parameter logic [7:0] LANE1_CODE     = 8'h2B,
    parameter logic [7:0] LANE2_CODE     = 8'h3B,
    parameter logic [7:0] LANE3_CODE     = 8'h42,
    parameter int         FIFO_DEPTH     = 4,
    parameter int         PREFIX_TIMEOUT = 200000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_done_tick,
    input  logic [7:0] rx_data,
    output logic       ev_valid,
    input  logic       ev_ready,
    output logic [1:0] ev_lane,
    output logic       ev_press,
    output logic [3:0] held,
    output logic       overflow,
    output logic       rx_clear
);
    localparam int TW = (PREFIX_TIMEOUT > 1) ? $clog2(PREFIX_TIMEOUT) : 1;

    decState_t  state;
    logic [TW-1:0] timer;
    logic       laneHit;
    logic [1:0] laneIdx;
    logic       pushEv;
    laneEvent_t pushEvt;
    laneEvent_t headEvt;
    logic       fifoFull;
    logic       fifoEmpty;
    logic       popEv;

    always_comb begin
        laneHit = 1'b1;
        laneIdx = 2'd0;
        if (rx_data == LANE0_CODE)      laneIdx = 2'd0;
        else if (rx_data == LANE1_CODE) laneIdx = 2'd1;
        else if (rx_data == LANE2_CODE) laneIdx = 2'd2;
        else if (rx_data == LANE3_CODE) laneIdx = 2'd3;
        else                            laneHit = 1'b0;
    end

    // Only edges of the held mask produce events, which filters typematic repeats.
    always_comb begin
        pushEv        = 1'b0;
        pushEvt.lane  = laneIdx;
        pushEvt.press = 1'b1;
        if (rx_done_tick && laneHit) begin
            if (state == IDLE && !held[laneIdx]) begin
                pushEv = 1'b1;
            end else if (state == BRK && held[laneIdx]) begin
                pushEv        = 1'b1;
                pushEvt.press = 1'b0;
            end
        end
    end

    assign popEv    = ev_valid && ev_ready;
    assign ev_valid = !fifoEmpty;
    assign ev_lane  = headEvt.lane;
    assign ev_press = headEvt.press;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            timer    <= '0;
            held     <= '0;
            overflow <= 1'b0;
            rx_clear <= 1'b0;
        end else begin
            rx_clear <= rx_done_tick;
            if (pushEv && fifoFull && !popEv) begin
                overflow <= 1'b1;
            end
            if (pushEv) begin
                held[laneIdx] <= pushEvt.press;
            end
            if (rx_done_tick) begin
                timer <= '0;
                case (state)
                    IDLE: begin
                        if (rx_data == SC_BREAK)    state <= BRK;
                        else if (rx_data == SC_EXT) state <= EXT;
                    end
                    EXT:     state <= (rx_data == SC_BREAK) ? EXT_BRK : IDLE;
                    default: state <= IDLE;
                endcase
            end else if (state != IDLE) begin
                // A stalled prefix (lost byte) must not swallow the next real key.
                if (timer == TW'(PREFIX_TIMEOUT - 1)) begin
                    state <= IDLE;
                    timer <= '0;
                end else begin
                    timer <= timer + 1'b1;
                end
            end else begin
                timer <= '0;
            end
        end
    end

    key_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(laneEvent_t))
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .wrEn   (pushEv),
        .wrData (pushEvt),
        .rdEn   (ev_ready),
        .rdData (headEvt),
        .empty  (fifoEmpty),
        .full   (fifoFull)
    );

endmodule

// File: tb/tb_ps2_lane_decoder.sv
// Scoreboard bench for ps2_lane_decoder: expected events queued at stimulus, checked on each pop.
module tb_ps2_lane_decoder;
    localparam int TO = 64;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_done_tick;
    logic [7:0] rx_data;
    logic       ev_valid;
    logic       ev_ready;
    logic [1:0] ev_lane;
    logic       ev_press;
    logic [3:0] held;
    logic       overflow;
    logic       rx_clear;

    int         checks = 0;
    int         errors = 0;
    logic [2:0] sbq[$];
    logic       lastTick = 1'b0;

    ps2_lane_decoder #(.PREFIX_TIMEOUT(TO)) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_done_tick (rx_done_tick),
        .rx_data      (rx_data),
        .ev_valid     (ev_valid),
        .ev_ready     (ev_ready),
        .ev_lane      (ev_lane),
        .ev_press     (ev_press),
        .held         (held),
        .overflow     (overflow),
        .rx_clear     (rx_clear)
    );

    always #5 clk = ~clk;

    task automatic checkEq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    // Inputs for the coming edge are already applied; a handshake seen here pops at that edge.
    task automatic monitor();
        logic [2:0] e;
        checkEq("ev_valid", 32'(ev_valid), 32'(sbq.size() != 0));
        checkEq("rx_clear", 32'(rx_clear), 32'(lastTick));
        if (ev_valid && ev_ready && sbq.size() != 0) begin
            e = sbq.pop_front();
            checkEq("event", 32'({ev_lane, ev_press}), 32'(e));
        end
    endtask

    task automatic step(input logic doTick, input logic [7:0] data, input logic ready,
                        input logic expEv, input logic [1:0] lane, input logic press);
        @(negedge clk);
        rx_done_tick = doTick;
        rx_data      = data;
        ev_ready     = ready;
        monitor();
        if (expEv) sbq.push_back({lane, press});
        lastTick = doTick;
    endtask

    task automatic tk(input logic [7:0] data, input logic ready,
                      input logic expEv, input logic [1:0] lane, input logic press);
        step(1'b1, data, ready, expEv, lane, press);
    endtask

    task automatic idle(input int n, input logic ready);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, ready, 1'b0, 2'd0, 1'b0);
    endtask

    initial begin
        reset        = 1'b1;
        rx_done_tick = 1'b0;
        rx_data      = 8'h00;
        ev_ready     = 1'b0;
        repeat (3) @(negedge clk);
        checkEq("rst_valid", 32'(ev_valid), 32'd0);
        checkEq("rst_lane", 32'({ev_lane, ev_press}), 32'd0);
        checkEq("rst_held", 32'(held), 32'd0);
        checkEq("rst_overflow", 32'(overflow), 32'd0);
        checkEq("rst_rx_clear", 32'(rx_clear), 32'd0);
        reset = 1'b0;

        // Press and release lane 0; the first idle step checks the N+1 latency.
        tk(8'h23, 1'b0, 1'b1, 2'd0, 1'b1);
        idle(1, 1'b0);
        checkEq("held_p0", 32'(held), 32'b0001);
        idle(2, 1'b1);
        tk(8'hF0, 1'b1, 1'b0, 2'd0, 1'b0);
        tk(8'h23, 1'b1, 1'b1, 2'd0, 1'b0);
        idle(3, 1'b1);
        checkEq("held_r0", 32'(held), 32'b0000);

        // Typematic repeats of lane 1 produce a single event.
        tk(8'h2B, 1'b0, 1'b1, 2'd1, 1'b1);
        tk(8'h2B, 1'b0, 1'b0, 2'd0, 1'b0);
        tk(8'h2B, 1'b0, 1'b0, 2'd0, 1'b0);
        idle(2, 1'b0);
        checkEq("held_rep", 32'(held), 32'b0010);
        idle(3, 1'b1);

        // Extended break of the lane 3 code is not a lane event.
        tk(8'hE0, 1'b1, 1'b0, 2'd0, 1'b0);
        tk(8'hF0, 1'b1, 1'b0, 2'd0, 1'b0);
        tk(8'h42, 1'b1, 1'b0, 2'd0, 1'b0);
        idle(2, 1'b1);
        checkEq("held_ext", 32'(held), 32'b0010);
        tk(8'h42, 1'b1, 1'b1, 2'd3, 1'b1);
        idle(2, 1'b1);
        checkEq("held_l3", 32'(held), 32'b1010);
        tk(8'hF0, 1'b1, 1'b0, 2'd0, 1'b0);
        tk(8'h2B, 1'b1, 1'b1, 2'd1, 1'b0);
        tk(8'hF0, 1'b1, 1'b0, 2'd0, 1'b0);
        tk(8'h42, 1'b1, 1'b1, 2'd3, 1'b0);
        idle(3, 1'b1);
        checkEq("held_clr", 32'(held), 32'b0000);

        // Break prefix abandoned after the timeout: the lane code is a make.
        tk(8'hF0, 1'b1, 1'b0, 2'd0, 1'b0);
        idle(TO, 1'b1);
        tk(8'h3B, 1'b1, 1'b1, 2'd2, 1'b1);
        idle(2, 1'b1);
        checkEq("held_to", 32'(held), 32'b0100);
        // A shorter gap keeps the break prefix alive.
        tk(8'hF0, 1'b1, 1'b0, 2'd0, 1'b0);
        idle(TO / 2, 1'b1);
        tk(8'h3B, 1'b1, 1'b1, 2'd2, 1'b0);
        idle(3, 1'b1);
        checkEq("held_short", 32'(held), 32'b0000);

        // Fill the queue, push+pop while full, then drop one event.
        tk(8'h23, 1'b0, 1'b1, 2'd0, 1'b1);
        tk(8'h2B, 1'b0, 1'b1, 2'd1, 1'b1);
        tk(8'h3B, 1'b0, 1'b1, 2'd2, 1'b1);
        tk(8'h42, 1'b0, 1'b1, 2'd3, 1'b1);
        tk(8'hF0, 1'b0, 1'b0, 2'd0, 1'b0);
        tk(8'h23, 1'b1, 1'b1, 2'd0, 1'b0);
        idle(1, 1'b0);
        checkEq("ovf_pushpop", 32'(overflow), 32'd0);
        checkEq("held_full", 32'(held), 32'b1110);
        tk(8'hF0, 1'b0, 1'b0, 2'd0, 1'b0);
        tk(8'h2B, 1'b0, 1'b0, 2'd0, 1'b0);
        idle(1, 1'b0);
        checkEq("ovf_drop", 32'(overflow), 32'd1);
        checkEq("held_drop", 32'(held), 32'b1100);

        // Reset mid-prefix clears everything, including the queued events.
        tk(8'hF0, 1'b0, 1'b0, 2'd0, 1'b0);
        @(negedge clk);
        rx_done_tick = 1'b0;
        reset        = 1'b1;
        #1;
        checkEq("mid_valid", 32'(ev_valid), 32'd0);
        checkEq("mid_held", 32'(held), 32'd0);
        checkEq("mid_overflow", 32'(overflow), 32'd0);
        checkEq("mid_rx_clear", 32'(rx_clear), 32'd0);
        sbq.delete();
        lastTick = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        tk(8'h23, 1'b1, 1'b1, 2'd0, 1'b1);
        idle(3, 1'b1);
        checkEq("held_post_rst", 32'(held), 32'b0001);
        checkEq("sb_empty", 32'(sbq.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
